peristaltic_pump_ctrl: RTL and testbench
========================================

Name: peristaltic_pump_ctrl

Overview:
- Sequencer upstream of the three-valve peristaltic pump cell and the three-way source mux cell.
- Generates the 6-phase pneumatic actuation pattern on the pump's pump1/pump2/pump3 air lines.
- Holds a one-hot source selection on the mux's sa/sb/sc lines for the whole run.
- A host starts a run of N strokes (or a continuous run) with a programmable phase duration, and gets busy/done handshake outputs.

Parameters:
- CNT_W, 16, width of phase_ticks and of the internal phase timer.
- STROKE_W, 8, width of strokes and stroke_cnt.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- start  input  1  run request, sampled at the rising clk edge
- stop  input  1  graceful stop request
- dir  input  1  0 = forward (in to out), 1 = reverse
- phase_ticks  input  CNT_W  cycles per phase; 0 is treated as 1
- strokes  input  STROKE_W  strokes per run; 0 = continuous until stop
- src_sel  input  2  0/1/2 select sa/sb/sc; 3 is invalid
- busy  output  1  run in progress
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse on a rejected start
- pump1, pump2, pump3  output  1 each  air lines; 1 = pressurised = valve closed
- sa, sb, sc  output  1 each  mux air lines; 1 = pressurised = selected path open
- stroke_cnt  output  STROKE_W  strokes completed in the current or last run

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state IDLE; pump1/2/3 = 1 (all closed); sa/sb/sc = 0; busy, done, err = 0; stroke_cnt = 0; timer = 0; phase = 0.
- Latching: start is accepted only in IDLE with src_sel != 3. On acceptance, dir, phase_ticks (T, with 0 mapped to 1), strokes (N) and src_sel are latched. Later changes to these inputs are ignored until the next accepted start.
- Rejected starts:
  - start in IDLE with src_sel == 3: err pulses for 1 cycle; state stays IDLE.
  - start while busy: ignored, no err.
- States:
  - IDLE: valves all closed; sa/sb/sc = 0; busy = 0.
  - SETTLE: valves all closed; selected mux line = 1; lasts T cycles.
  - RUN: phase pattern applied; each phase lasts T cycles.
  - FINISH: valves all closed; mux line still held; lasts T cycles.
  - Return to IDLE: done = 1 for 1 cycle, busy = 0, mux lines = 0.
- Timing: with the accepting edge as cycle 0, SETTLE occupies cycles 1..T. RUN occupies the next 6·N·T cycles. FINISH occupies the next T cycles. done is high in cycle (2+6N)·T+1. busy is high from cycle 1 through the last FINISH cycle.
- Phase table (pump1, pump2, pump3):
  - P0 = 1,0,1
  - P1 = 1,0,0
  - P2 = 1,1,0
  - P3 = 0,1,0
  - P4 = 0,1,1
  - P5 = 0,0,1
- Phase order: forward steps P0→P5, reverse steps P5→P0. Exactly one line toggles per phase boundary. The outputs are registered and change on the edge that enters the phase.
- Stroke counting: one stroke = 6 phases. stroke_cnt is cleared on an accepted start and increments on the edge that completes the last phase of a stroke. When stroke_cnt reaches N (N != 0), the block goes to FINISH.
- Continuous mode (N = 0): stroke_cnt wraps modulo 2^STROKE_W; the run continues until stop.
- stop:
  - In RUN: the current phase completes its T cycles, then the block goes to FINISH. A partial stroke is not counted.
  - In SETTLE: the block goes to FINISH after the SETTLE interval; RUN is skipped.
  - In IDLE or FINISH: ignored.
  - stop and the stroke-completion edge together: FINISH, counted once.
- Reset mid-run: immediate return to reset values, with no done pulse.
- The timer is a down-counter loaded with T-1 on each state or phase entry; the advance happens at 0. No combinational path from any input to any output.

Optional Feature:
- Macro: PUMP_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort high in any non-IDLE state forces, on the next edge: all valves closed, sa/sb/sc = 0, state IDLE, busy = 0, no done.
  - err pulses for 1 cycle.
  - stroke_cnt holds its value.
  - abort has priority over stop and over stroke completion.
- When undefined: the port is absent and the behaviour is exactly as above.

Test Plan:
- Reset, then idle 10 cycles: pump1/2/3 = 1,1,1; sa/sb/sc = 0; busy = done = err = 0.
- start with T=3, N=2, dir=0, src_sel=1: sb=1 from cycle 1. Pattern P0..P5 twice, each phase held 3 cycles, starting at cycle 4. done at cycle 43. stroke_cnt = 2.
- dir=1, T=0, N=1: phases P5,P4,…,P0, one cycle each. done at cycle 9.
- N=0, T=2: assert stop in the middle of the 3rd phase of stroke 5. The phase completes, FINISH lasts 2 cycles, then done. stroke_cnt = 4.
- Rejects: start with src_sel=3 gives an err pulse and busy stays 0. start mid-run is ignored, with the latched parameters unchanged.
- rst asserted mid-RUN, asynchronously between edges: outputs return to reset values immediately, with no done. With PUMP_ABORT_EN, abort in RUN gives IDLE next edge, an err pulse, no done, and stroke_cnt held.

Source files
------------

// File: rtl/peristaltic_pump_ctrl.sv
// Six-phase pneumatic sequencer for a three-valve peristaltic pump and a three-way source mux.
// Optional abort input is compiled in when PUMP_ABORT_EN is defined.
module peristaltic_pump_ctrl #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned STROKE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                dir,
    input  logic [CNT_W-1:0]    phase_ticks,
    input  logic [STROKE_W-1:0] strokes,
    input  logic [1:0]          src_sel,
`ifdef PUMP_ABORT_EN
    input  logic                abort,
`endif
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                pump1,
    output logic                pump2,
    output logic                pump3,
    output logic                sa,
    output logic                sb,
    output logic                sc,
    output logic [STROKE_W-1:0] stroke_cnt
);

    typedef enum logic [1:0] {StIdle, StSettle, StRun, StFinish} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]    t_q, t_d;
    logic [CNT_W-1:0]    t_new;
    logic [2:0]          phase_q, phase_d;
    logic [STROKE_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [STROKE_W-1:0] n_q, n_d;
    logic                dir_q, dir_d;
    logic [1:0]          sel_q, sel_d;
    logic                stop_q, stop_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [2:0]          pump_q, pump_d;
    logic [2:0]          mux_q, mux_d;
    logic                stop_req, last_phase;
    logic [2:0]          phase_nxt;

    // Pump pattern as {pump1, pump2, pump3}; adjacent phases differ in exactly one line.
    function automatic logic [2:0] phase_pattern(input logic [2:0] ph);
        unique case (ph)
            3'd0:    phase_pattern = 3'b101;
            3'd1:    phase_pattern = 3'b100;
            3'd2:    phase_pattern = 3'b110;
            3'd3:    phase_pattern = 3'b010;
            3'd4:    phase_pattern = 3'b011;
            3'd5:    phase_pattern = 3'b001;
            default: phase_pattern = 3'b111;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            t_q     <= CNT_W'(1);
            phase_q <= 3'd0;
            cnt_q   <= '0;
            n_q     <= '0;
            dir_q   <= 1'b0;
            sel_q   <= 2'd0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            pump_q  <= 3'b111;
            mux_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            t_q     <= t_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            dir_q   <= dir_d;
            sel_q   <= sel_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            pump_q  <= pump_d;
            mux_q   <= mux_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        t_d        = t_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        dir_d      = dir_q;
        sel_d      = sel_q;
        stop_d     = stop_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        t_new      = (phase_ticks == '0) ? CNT_W'(1) : phase_ticks;
        stop_req   = stop_q | stop;
        last_phase = dir_q ? (phase_q == 3'd0) : (phase_q == 3'd5);
        cnt_inc    = cnt_q + STROKE_W'(1);
        if (dir_q) phase_nxt = (phase_q == 3'd0) ? 3'd5 : phase_q - 3'd1;
        else       phase_nxt = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (src_sel == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StSettle;
                        t_d     = t_new;
                        timer_d = t_new - CNT_W'(1);
                        n_d     = strokes;
                        dir_d   = dir;
                        sel_d   = src_sel;
                        cnt_d   = '0;
                        stop_d  = 1'b0;
                    end
                end
            end
            StSettle: begin
                if (stop) stop_d = 1'b1;
                if (timer_q == '0) begin
                    timer_d = t_q - CNT_W'(1);
                    if (stop_req) begin
                        state_d = StFinish;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = StRun;
                        phase_d = dir_q ? 3'd5 : 3'd0;
                    end
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            StRun: begin
                if (stop) stop_d = 1'b1;
                if (timer_q == '0) begin
                    timer_d = t_q - CNT_W'(1);
                    if (last_phase) cnt_d = cnt_inc;
                    // A pending stop only ends the run at a phase boundary; partial strokes are not counted.
                    if (stop_req || (last_phase && n_q != '0 && cnt_inc == n_q)) begin
                        state_d = StFinish;
                        stop_d  = 1'b0;
                    end else begin
                        phase_d = phase_nxt;
                    end
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            StFinish: begin
                if (timer_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
        endcase

`ifdef PUMP_ABORT_EN
        if (abort && state_q != StIdle) begin
            state_d = StIdle;
            timer_d = '0;
            cnt_d   = cnt_q;
            stop_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end
`endif
    end

    // Registered outputs are derived from the next state so they change on the entering edge.
    always_comb begin
        pump_d = 3'b111;
        mux_d  = 3'b000;
        busy_d = (state_d != StIdle);
        if (state_d == StRun) pump_d = phase_pattern(phase_d);
        if (state_d != StIdle) begin
            unique case (sel_d)
                2'd0:    mux_d = 3'b100;
                2'd1:    mux_d = 3'b010;
                2'd2:    mux_d = 3'b001;
                default: mux_d = 3'b000;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign pump1      = pump_q[2];
    assign pump2      = pump_q[1];
    assign pump3      = pump_q[0];
    assign sa         = mux_q[2];
    assign sb         = mux_q[1];
    assign sc         = mux_q[0];
    assign stroke_cnt = cnt_q;

endmodule

// File: tb/tb_peristaltic_pump_ctrl.sv
// Directed bench for peristaltic_pump_ctrl; define PUMP_ABORT_EN to also exercise abort.
module tb_peristaltic_pump_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, dir;
    logic [15:0] phase_ticks;
    logic [7:0]  strokes;
    logic [1:0]  src_sel;
    logic        busy, done, err;
    logic        pump1, pump2, pump3, sa, sb, sc;
    logic [7:0]  stroke_cnt;
`ifdef PUMP_ABORT_EN
    logic        abort;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    peristaltic_pump_ctrl #(.CNT_W(16), .STROKE_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .dir         (dir),
        .phase_ticks (phase_ticks),
        .strokes     (strokes),
        .src_sel     (src_sel),
`ifdef PUMP_ABORT_EN
        .abort       (abort),
`endif
        .busy        (busy),
        .done        (done),
        .err         (err),
        .pump1       (pump1),
        .pump2       (pump2),
        .pump3       (pump3),
        .sa          (sa),
        .sb          (sb),
        .sc          (sc),
        .stroke_cnt  (stroke_cnt)
    );

    // Packed view: {busy, done, err, pump1, pump2, pump3, sa, sb, sc, stroke_cnt}
    function automatic logic [16:0] obs();
        return {busy, done, err, pump1, pump2, pump3, sa, sb, sc, stroke_cnt};
    endfunction

    function automatic logic [2:0] pat(input int ph);
        case (ph)
            0:       return 3'b101;
            1:       return 3'b100;
            2:       return 3'b110;
            3:       return 3'b010;
            4:       return 3'b011;
            default: return 3'b001;
        endcase
    endfunction

    // Expected outputs in cycle k of a run with phase length t and p phases spent in RUN.
    function automatic logic [16:0] exp_vec(input int t, input int p, input bit d,
                                            input int sel, input int k);
        int rs, re, fe, c, ph;
        logic       b, dn;
        logic [2:0] pm, mx;
        rs = t + 1;
        re = t + p * t;
        fe = re + t;
        b  = (k >= 1 && k <= fe);
        dn = (k == fe + 1);
        mx = 3'b000;
        if (b) mx = (sel == 0) ? 3'b100 : (sel == 1) ? 3'b010 : 3'b001;
        pm = 3'b111;
        if (k >= rs && k <= re) begin
            ph = ((k - rs) / t) % 6;
            if (d) ph = 5 - ph;
            pm = pat(ph);
        end
        c = (k >= rs) ? (k - rs) / t : 0;
        if (c > p) c = p;
        return {b, dn, 1'b0, pm, mx, 8'((c / 6) % 256)};
    endfunction

    task automatic chk(input string tag, input logic [16:0] o, input logic [16:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // Starts a run at the current negedge and checks cycles 1..kmax against exp_vec.
    task automatic run(input int t_drv, input int t_eff, input int n, input int p, input bit d,
                       input int sel, input int stop_at, input int junk_at, input int kmax,
                       input string name);
        dir         = d;
        phase_ticks = 16'(t_drv);
        strokes     = 8'(n);
        src_sel     = 2'(sel);
        start       = 1'b1;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            chk($sformatf("%s c%0d", name, k), obs(), exp_vec(t_eff, p, d, sel, k));
            if (k == 1) start = 1'b0;
            stop = (k == stop_at);
            if (junk_at != 0 && k == junk_at) begin
                start       = 1'b1;
                dir         = ~d;
                phase_ticks = 16'd7;
                strokes     = 8'd5;
                src_sel     = 2'd2;
            end
            if (junk_at != 0 && k == junk_at + 1) start = 1'b0;
        end
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0;
        phase_ticks = '0; strokes = '0; src_sel = '0;
`ifdef PUMP_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d", i), obs(), {3'b000, 3'b111, 3'b000, 8'd0});
        end

        // Forward T=3 N=2 on sb, with an ignored start at cycle 10.
        run(3, 3, 2, 12, 1'b0, 1, 0, 10, 44, "fwd");
        // Reverse with T=0 treated as 1, N=1 on sa.
        run(0, 1, 1, 6, 1'b1, 0, 0, 0, 10, "rev");

        // Start with invalid source: err pulse only.
        src_sel = 2'd3;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rej_err", obs(), {3'b001, 3'b111, 3'b000, 8'd1});
        @(negedge clk);
        chk("rej_clr", obs(), {3'b000, 3'b111, 3'b000, 8'd1});

        // Continuous T=2 on sc, stop mid 3rd phase of stroke 5 -> 27 phases in RUN.
        run(2, 2, 0, 27, 1'b0, 2, 55, 0, 60, "cont");

        // Asynchronous reset mid-RUN.
        run(2, 2, 3, 18, 1'b0, 0, 0, 0, 12, "rstrun");
        #2 rst = 1'b1;
        #1 chk("rst_async", obs(), {3'b000, 3'b111, 3'b000, 8'd0});
        @(negedge clk);
        chk("rst_hold", obs(), {3'b000, 3'b111, 3'b000, 8'd0});
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_after%0d", i), obs(), {3'b000, 3'b111, 3'b000, 8'd0});
        end

`ifdef PUMP_ABORT_EN
        // Abort in stroke 2 of a 3-stroke run.
        run(2, 2, 3, 18, 1'b0, 0, 0, 0, 20, "abrun");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_err", obs(), {3'b001, 3'b111, 3'b000, 8'd1});
        @(negedge clk);
        chk("abort_clr", obs(), {3'b000, 3'b111, 3'b000, 8'd1});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
